// File: rtl/lsu_pkg.sv
// lsu_pkg: the types and constants shared by the load/store unit and its
// lane-alignment helper.
//   lsu_state_e     - load_store_unit controller states
//   F3_*            - RISC-V funct3 codes for access size and sign
//   lsu_cause_e     - fault cause reported on resp_cause
//   lsu_fault_cause - classifies one request (illegal > misaligned > range)
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_RANGE    = 2'd2,
        CAUSE_ILLEGAL  = 2'd3
    } lsu_cause_e;

    // Unsigned variants exist only for loads; stores have no sign to choose.
    function automatic lsu_cause_e lsu_fault_cause(
        input logic       store,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo,
        input logic       out_of_range
    );
        logic legal;
        logic misaligned;
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~store;
            default:          legal = 1'b0;
        endcase
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        if (!legal)           return CAUSE_ILLEGAL;
        else if (misaligned)  return CAUSE_MISALIGN;
        else if (out_of_range) return CAUSE_RANGE;
        else                  return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane handling for the load/store unit.
// Ports:
//   i_word     - word read from data memory
//   i_wdata    - store data, right-aligned
//   i_lane     - byte address bits [1:0]
//   i_funct3   - size/sign code
//   o_load     - selected lane, sign- or zero-extended to 32 bits
//   o_store    - i_word with the store lane replaced (whole i_wdata for SW)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_load,
    output logic [31:0] o_store
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_lane)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_load = i_word;
        case (i_funct3)
            F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load = {{16{w_half[15]}}, w_half};
            F3_BU:   o_load = {24'h000000, w_byte};
            F3_HU:   o_load = {16'h0000, w_half};
            default: o_load = i_word;
        endcase
    end

    always_comb begin
        o_store = i_word;
        case (i_funct3[1:0])
            2'b00: begin
                case (i_lane)
                    2'd0: o_store[7:0]   = i_wdata[7:0];
                    2'd1: o_store[15:8]  = i_wdata[7:0];
                    2'd2: o_store[23:16] = i_wdata[7:0];
                    2'd3: o_store[31:24] = i_wdata[7:0];
                    default: o_store = i_word;
                endcase
            end
            2'b01: begin
                if (i_lane[1]) o_store[31:16] = i_wdata[15:0];
                else           o_store[15:0]  = i_wdata[15:0];
            end
            default: o_store = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage in front of a word-wide data memory
// without byte enables. Sub-word stores are done as read-modify-write.
// Faulted requests never touch memory.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request; fault classified at accept
// LOAD  | memory read, extended lane registered
// MERGE | memory read, store lane merged into the old word
// WRITE | merged (or full SW) word written
// RESP  | one-cycle response pulse
//
// Ports:
//   clock, reset             - sole clock; synchronous active-high reset
//   req_valid/req_ready      - request handshake
//   req_store, req_funct3    - direction and size/sign code
//   req_addr, req_wdata      - byte address, right-aligned store data
//   resp_valid               - one-cycle completion pulse (no backpressure)
//   resp_rdata               - extended load data; 0 for stores and faults
//   resp_fault, resp_cause   - fault flag and cause
//   mem_read_enable, mem_write_enable, mem_addr, mem_write_data,
//   mem_read_data            - data memory (combinational read)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DMEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [1:0]  resp_cause,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    // 33 bits so the limit cannot wrap for a memory filling the address space.
    localparam logic [32:0] ADDR_LIMIT = 33'(DMEM_WORDS) * 33'd4;

    lsu_state_e  r_state;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_wword;
    logic [31:0] r_rdata;
    logic        r_fault;
    lsu_cause_e  r_cause;

    logic        w_accept;
    logic        w_out_of_range;
    lsu_cause_e  w_cause;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;
    logic        w_mem_phase;

    assign req_ready      = (r_state == IDLE) && !reset;
    assign w_accept       = req_valid && req_ready;
    assign w_out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);
    assign w_cause        = lsu_fault_cause(req_store, req_funct3, req_addr[1:0],
                                            w_out_of_range);

    lsu_align u_align (
        .i_word   (mem_read_data),
        .i_wdata  (r_wdata),
        .i_lane   (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_load   (w_load_data),
        .o_store  (w_store_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_wword  <= 32'd0;
            r_rdata  <= 32'd0;
            r_fault  <= 1'b0;
            r_cause  <= CAUSE_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        // SW goes straight to WRITE with the full word.
                        r_wword  <= req_wdata;
                        r_rdata  <= 32'd0;
                        r_fault  <= (w_cause != CAUSE_NONE);
                        r_cause  <= w_cause;
                        if (w_cause != CAUSE_NONE) r_state <= RESP;
                        else if (!req_store)       r_state <= LOAD;
                        else if (req_funct3 == F3_W) r_state <= WRITE;
                        else                       r_state <= MERGE;
                    end
                end
                LOAD: begin
                    r_rdata <= w_load_data;
                    r_state <= RESP;
                end
                MERGE: begin
                    r_wword <= w_store_word;
                    r_state <= WRITE;
                end
                WRITE:   r_state <= RESP;
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_mem_phase      = (r_state == LOAD) || (r_state == MERGE) || (r_state == WRITE);
    assign mem_read_enable  = (r_state == LOAD) || (r_state == MERGE);
    // Reset overrides WRITE combinationally so an aborted store never lands.
    assign mem_write_enable = (r_state == WRITE) && !reset;
    assign mem_addr         = w_mem_phase ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem_write_data   = (r_state == WRITE) ? r_wword : 32'd0;

    assign resp_valid = (r_state == RESP);
    assign resp_rdata = resp_valid ? r_rdata : 32'd0;
    assign resp_fault = resp_valid && r_fault;
    assign resp_cause = resp_valid ? r_cause : CAUSE_NONE;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized requests
// checked against a byte-addressed reference memory model.
module tb_load_store_unit;

    localparam int DMEM_WORDS = 256;
    localparam int NBYTES     = DMEM_WORDS * 4;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [1:0]  resp_cause;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] dmem [DMEM_WORDS];
    logic [7:0]  ref_bytes [NBYTES];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    int n_vec;
    int n_err;

    load_store_unit #(.DMEM_WORDS(DMEM_WORDS)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_store        (req_store),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_fault       (resp_fault),
        .resp_cause       (resp_cause),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_read_data = dmem[mem_addr[9:2]];

    always @(posedge clock) begin
        if (pre_en) dmem[pre_idx] <= pre_data;
        else if (mem_write_enable) dmem[mem_addr[9:2]] <= mem_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, little-endian, arithmetic extension.
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] e_rdata,
                         output logic e_fault, output logic [1:0] e_cause, output int e_lat,
                         output int e_rd, output int e_wr, output logic [31:0] e_wword);
        bit legal;
        int nb;
        int base;
        logic [31:0] v;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        nb = 1 << f3[1:0];
        if (!legal)                          e_cause = 2'd3;
        else if ((addr % nb) != 0)           e_cause = 2'd1;
        else if (addr >= 32'(NBYTES))        e_cause = 2'd2;
        else                                 e_cause = 2'd0;
        e_fault = (e_cause != 2'd0);
        e_rdata = 32'd0;
        e_wword = 32'd0;
        e_rd = 0;
        e_wr = 0;
        e_lat = 1;
        if (!e_fault) begin
            base = int'(addr[9:0]);
            if (st) begin
                for (int i = 0; i < nb; i++) ref_bytes[base + i] = wd[8*i +: 8];
                base = int'(addr[9:2]) * 4;
                e_wword = {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
                e_wr = 1;
                e_rd = (nb < 4) ? 1 : 0;
                e_lat = (nb < 4) ? 3 : 2;
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[base + i]) << (8*i));
                if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                e_rdata = v;
                e_rd = 1;
                e_lat = 2;
            end
        end
    endtask

    // Issue one request from a post-edge slot; returns at the response cycle.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input bit hold,
                          output int waits, output logic [31:0] got_rdata);
        logic [31:0] e_rdata, e_wword, w_data, w_addr;
        logic        e_fault, g_fault;
        logic [1:0]  e_cause, g_cause;
        int          e_lat, e_rd, e_wr, n_rd, n_wr, lat;
        bit          got, ready_hi;
        model(st, f3, addr, wd, e_rdata, e_fault, e_cause, e_lat, e_rd, e_wr, e_wword);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        waits = 0;
        got_rdata = 32'd0;
        while (!req_ready && waits < 50) begin
            @(posedge clock); #1;
            waits++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        if (!hold) req_valid = 1'b0;
        n_rd = 0; n_wr = 0; lat = 0; got = 0; ready_hi = 0;
        w_data = 32'd0; w_addr = 32'd0; g_fault = 1'b0; g_cause = 2'd0;
        for (int c = 1; c <= 8 && !got; c++) begin
            if (req_ready) ready_hi = 1;
            if (mem_read_enable) begin
                n_rd++;
                chk("rd_addr", mem_addr, {addr[31:2], 2'b00});
            end
            if (mem_write_enable) begin
                n_wr++;
                w_data = mem_write_data;
                w_addr = mem_addr;
            end
            if (resp_valid) begin
                got = 1;
                lat = c;
                got_rdata = resp_rdata;
                g_fault = resp_fault;
                g_cause = resp_cause;
            end else begin
                @(posedge clock); #1;
            end
        end
        if (!got) begin
            chk("resp_timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency", lat, e_lat);
        chk("rdata", got_rdata, e_rdata);
        chk("fault", 32'(g_fault), 32'(e_fault));
        chk("cause", 32'(g_cause), 32'(e_cause));
        chk("n_reads", n_rd, e_rd);
        chk("n_writes", n_wr, e_wr);
        chk("ready_low", 32'(ready_hi), 32'd0);
        if (e_wr != 0) begin
            chk("wr_data", w_data, e_wword);
            chk("wr_addr", w_addr, {addr[31:2], 2'b00});
        end
    endtask

    initial begin
        int          waits;
        logic [31:0] rd;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        pre_en = 1'b1;
        pre_idx = 8'd0;
        pre_data = 32'd0;

        // Preload under reset; also exercises req_valid-with-reset.
        req_valid = 1'b1;
        for (int i = 0; i < DMEM_WORDS; i++) begin
            pre_idx  = 8'(i);
            pre_data = (i == 4) ? 32'h8081_8283 : $urandom;
            for (int b = 0; b < 4; b++) ref_bytes[i*4 + b] = pre_data[8*b +: 8];
            @(posedge clock); #1;
        end
        pre_en = 1'b0;
        req_valid = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_fault", {30'd0, resp_cause} | 32'(resp_fault), 32'd0);
        chk("rst_mem_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Directed loads on word 0x10 = 0x80818283.
        do_req(1'b0, 3'b000, 32'h11, 32'd0, 1'b0, waits, rd); chk("LB_0x11", rd, 32'hFFFF_FF82);
        do_req(1'b0, 3'b100, 32'h13, 32'd0, 1'b0, waits, rd); chk("LBU_0x13", rd, 32'h0000_0080);
        do_req(1'b0, 3'b001, 32'h12, 32'd0, 1'b0, waits, rd); chk("LH_0x12", rd, 32'hFFFF_8081);
        do_req(1'b0, 3'b101, 32'h10, 32'd0, 1'b0, waits, rd); chk("LHU_0x10", rd, 32'h0000_8283);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, 1'b0, waits, rd); chk("LW_0x10", rd, 32'h8081_8283);

        // Byte store read-modify-write, then read back.
        do_req(1'b1, 3'b000, 32'h12, 32'h1234_56AA, 1'b0, waits, rd); chk("SB_rdata", rd, 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, 1'b0, waits, rd); chk("LW_after_SB", rd, 32'h80AA_8283);

        // Faults.
        do_req(1'b0, 3'b010, 32'h06, 32'd0, 1'b0, waits, rd);
        do_req(1'b1, 3'b010, 32'h400, 32'h5555_5555, 1'b0, waits, rd);
        do_req(1'b0, 3'b011, 32'h10, 32'd0, 1'b0, waits, rd);
        do_req(1'b1, 3'b111, 32'h401, 32'h5555_5555, 1'b0, waits, rd);

        // Restore word 0x10, then abort a SW with reset while in WRITE.
        do_req(1'b1, 3'b010, 32'h10, 32'h8081_8283, 1'b0, waits, rd);
        @(posedge clock); #1;
        req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("pre_abort_we", 32'(mem_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_we_gated", 32'(mem_write_enable), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        begin
            bit saw_resp;
            saw_resp = 0;
            for (int c = 0; c < 5; c++) begin
                if (resp_valid) saw_resp = 1;
                @(posedge clock); #1;
            end
            chk("abort_no_resp", 32'(saw_resp), 32'd0);
        end
        chk("abort_mem", dmem[4], 32'h8081_8283);

        // Back-to-back with req_valid held.
        do_req(1'b0, 3'b010, 32'h10, 32'd0, 1'b1, waits, rd); chk("b2b_first", rd, 32'h8081_8283);
        do_req(1'b0, 3'b000, 32'h11, 32'd0, 1'b0, waits, rd); chk("b2b_second", rd, 32'hFFFF_FF82);
        chk("b2b_gap", waits, 32'd1);

        // Randomized requests.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'h400 + $urandom_range(0, 4095);
            else if (sel == 1) a = $urandom;
            else               a = $urandom_range(0, 63);
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                   (n != 199) && ($urandom_range(0, 1) == 1), waits, rd);
        end
        req_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;

        for (int i = 0; i < DMEM_WORDS; i++)
            chk("final_mem", dmem[i], {ref_bytes[i*4+3], ref_bytes[i*4+2], ref_bytes[i*4+1], ref_bytes[i*4]});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
